// File: rtl/instruction_encode_stream_if.sv
// Handshake bundle for instruction_encode_stream.
// master: bundle producer and word sink. slave: the encoder.
interface instruction_encode_stream_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_opcode;
    logic [2:0]  in_rd;
    logic [2:0]  in_rs1;
    logic [2:0]  in_rs2;
    logic [3:0]  in_func;
    logic [8:0]  in_offset;
    logic        in_jmp;
    logic [15:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_word;
    logic        out_last;

    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_func,
               in_offset, in_jmp, in_imm, out_ready,
        input  in_ready, out_valid, out_word, out_last
    );

    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_func,
               in_offset, in_jmp, in_imm, out_ready,
        output in_ready, out_valid, out_word, out_last
    );
endinterface

// File: rtl/instruction_encode_stream.sv
// instruction_encode_stream: packs decoder field bundles into 16-bit
// instruction words and streams them out. I_TYPE/M_TYPE emit a second
// word carrying the immediate. Intake halts once SYS_END is emitted.
// Optional macro INSTR_ENC_CHECK_EN: inconsistent J_TYPE bundles and
// undefined opcodes are accepted but dropped, with a one-cycle err pulse.
module instruction_encode_stream #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    instruction_encode_stream_if.slave bus,
    output logic [CNT_W-1:0]         words_out,
    output logic                     halted,
    output logic                     err
);

    typedef enum logic [2:0] {
        R_TYPE  = 3'd0,
        I_TYPE  = 3'd1,
        B_TYPE  = 3'd2,
        J_TYPE  = 3'd3,
        M_TYPE  = 3'd4,
        SYS_END = 3'd5
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE,
        W0,
        W1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] word_q, word_d;
    logic [15:0] imm_q, imm_d;
    logic        last_q, last_d;
    logic        sys_q, sys_d;
    logic        halted_d;

    opcode_t     op;
    logic [15:0] enc_word;
    logic        double_word;
    logic        handshake;
    logic        accept;
    logic        reject;

    assign op            = opcode_t'(bus.in_opcode);
    assign bus.out_valid = (state_q != IDLE);
    assign bus.out_word  = word_q;
    assign bus.out_last  = last_q;
    assign handshake     = bus.out_valid & bus.out_ready;
    // The SYS_END word's own handshake must not open intake for a new bundle.
    assign bus.in_ready  = !halted & ((state_q == IDLE) | (handshake & last_q & !sys_q));
    assign accept        = bus.in_valid & bus.in_ready;

`ifdef INSTR_ENC_CHECK_EN
    assign reject = (bus.in_opcode > SYS_END) |
                    ((op == J_TYPE) & (bus.in_jmp != bus.in_offset[2]));
`else
    assign reject = 1'b0;
`endif

    // Field packing of the incoming bundle into word0.
    always_comb begin
        enc_word    = '0;
        double_word = 1'b0;
        case (op)
            R_TYPE:  enc_word = {bus.in_func, bus.in_rd, bus.in_rs2, bus.in_rs1, bus.in_opcode};
            I_TYPE: begin
                enc_word    = {bus.in_func, bus.in_rd, 3'b000, bus.in_rs1, bus.in_opcode};
                double_word = 1'b1;
            end
            B_TYPE:  enc_word = {bus.in_func[2:0], bus.in_offset[3:0], bus.in_rs2, bus.in_rs1, bus.in_opcode};
            J_TYPE:  enc_word = {bus.in_offset[8:5], bus.in_rd, bus.in_offset[4:3], bus.in_jmp,
                                 bus.in_offset[1:0], 1'b0, bus.in_opcode};
            M_TYPE: begin
                enc_word    = {bus.in_func, bus.in_rd, bus.in_rs2, bus.in_rs1, bus.in_opcode};
                double_word = 1'b1;
            end
            default: enc_word = {13'b0, bus.in_opcode};
        endcase
    end

    // Next-state: retire/advance on output handshake, then load on accept.
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        imm_d    = imm_q;
        last_d   = last_q;
        sys_d    = sys_q;
        halted_d = halted;
        if (handshake) begin
            if (last_q) begin
                state_d = IDLE;
                if (sys_q) begin
                    halted_d = 1'b1;
                end
            end else begin
                state_d = W1;
                word_d  = imm_q;
                last_d  = 1'b1;
            end
        end
        if (accept) begin
            if (reject) begin
                state_d = IDLE;
            end else begin
                state_d = W0;
                word_d  = enc_word;
                last_d  = !double_word;
                imm_d   = bus.in_imm;
                sys_d   = (op == SYS_END);
            end
        end
    end

    // State, output word registers and word counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            word_q    <= '0;
            imm_q     <= '0;
            last_q    <= 1'b0;
            sys_q     <= 1'b0;
            halted    <= 1'b0;
            err       <= 1'b0;
            words_out <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            imm_q   <= imm_d;
            last_q  <= last_d;
            sys_q   <= sys_d;
            halted  <= halted_d;
            err     <= accept & reject;
            if (handshake) begin
                words_out <= words_out + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_instruction_encode_stream.sv
// Scoreboard bench for instruction_encode_stream: a driver pushes the
// expected word stream for each accepted bundle, a negedge monitor pops
// and compares on every output handshake. A CNT_W=2 copy shares stimulus.
module tb_instruction_encode_stream;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    instruction_encode_stream_if bus0();
    instruction_encode_stream_if bus1();

    logic [15:0] words_out;
    logic [1:0]  words_out2;
    logic        halted, halted2, err, err2;

    instruction_encode_stream #(.CNT_W(16)) dut (
        .clock(clock), .reset(reset), .bus(bus0.slave),
        .words_out(words_out), .halted(halted), .err(err)
    );

    instruction_encode_stream #(.CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .bus(bus1.slave),
        .words_out(words_out2), .halted(halted2), .err(err2)
    );

    assign bus1.in_valid  = bus0.in_valid;
    assign bus1.in_opcode = bus0.in_opcode;
    assign bus1.in_rd     = bus0.in_rd;
    assign bus1.in_rs1    = bus0.in_rs1;
    assign bus1.in_rs2    = bus0.in_rs2;
    assign bus1.in_func   = bus0.in_func;
    assign bus1.in_offset = bus0.in_offset;
    assign bus1.in_jmp    = bus0.in_jmp;
    assign bus1.in_imm    = bus0.in_imm;
    assign bus1.out_ready = bus0.out_ready;

    typedef struct {
        logic [15:0] w;
        bit          last;
        bit          sys;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int unsigned tb_cnt = 0;
    bit          tb_halted = 1'b0;
    int          exp_err = 0;
    int          obs_err = 0;
    int          obs_err2 = 0;
    logic [15:0] seen_word = '0;
    int          rdy_mode = 0;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_word = '0;
    logic        prev_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, expv, $time);
        end
    endtask

    // Reference: word values built arithmetically from the field map.
    task automatic push_model(input int op, input int rd, input int rs1, input int rs2,
                              input int func, input int off, input int jmp, input int imm);
        int w0;
        int low;
        bit rej;
        bit dbl;
        exp_t e;
        rej = 1'b0;
`ifdef INSTR_ENC_CHECK_EN
        rej = (op > 5) || (op == 3 && jmp != ((off / 4) % 2));
`endif
        if (rej) begin
            exp_err++;
            return;
        end
        dbl = (op == 1) || (op == 4);
        case (op)
            0, 4:    w0 = op + rs1 * 8 + rs2 * 64 + rd * 512 + func * 4096;
            1:       w0 = op + rs1 * 8 + rd * 512 + func * 4096;
            2:       w0 = op + rs1 * 8 + rs2 * 64 + (off % 16) * 512 + (func % 8) * 8192;
            3: begin
                low = off % 32;
                low = low - (low & 4) + jmp * 4;
                w0  = op + low * 16 + rd * 512 + (off / 32) * 4096;
            end
            default: w0 = op;
        endcase
        e.w = w0[15:0]; e.last = !dbl; e.sys = (op == 5);
        q.push_back(e);
        if (dbl) begin
            e.w = imm[15:0]; e.last = 1'b1; e.sys = 1'b0;
            q.push_back(e);
        end
    endtask

    task automatic set_fields(input int op, input int rd, input int rs1, input int rs2,
                              input int func, input int off, input int jmp, input int imm);
        bus0.in_opcode = op[2:0];
        bus0.in_rd     = rd[2:0];
        bus0.in_rs1    = rs1[2:0];
        bus0.in_rs2    = rs2[2:0];
        bus0.in_func   = func[3:0];
        bus0.in_offset = off[8:0];
        bus0.in_jmp    = jmp[0];
        bus0.in_imm    = imm[15:0];
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int op, input int rd, input int rs1, input int rs2,
                        input int func, input int off, input int jmp, input int imm);
        bit acc;
        acc = 1'b0;
        set_fields(op, rd, rs1, rs2, func, off, jmp, imm);
        bus0.in_valid = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            if (bus0.in_ready) begin
                push_model(op, rd, rs1, rs2, func, off, jmp, imm);
                acc = 1'b1;
                break;
            end
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1;
        bus0.in_valid = 1'b0;
    endtask

    task automatic send_rand(input bit allow_sys);
        int op;
        op = int'($urandom_range(0, 7));
        if (op == 5 && !allow_sys) op = 0;
        send(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 511)), int'($urandom_range(0, 1)),
             int'($urandom_range(0, 65535)));
    endtask

    task automatic drain();
        for (int i = 0; i < 1000 && !(q.size() == 0 && !bus0.out_valid); i++) begin
            @(posedge clock);
            #1;
        end
        chk("drain", 32'(q.size() == 0 && !bus0.out_valid), 32'd1);
    endtask

    // Sink ready generator; updates at posedge+2 so directed code can switch modes at +1.
    initial begin
        bus0.out_ready = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            case (rdy_mode)
                0:       bus0.out_ready = 1'b0;
                1:       bus0.out_ready = 1'b1;
                default: bus0.out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: scoreboard pop on handshake, hold stability, in_ready, status.
    always @(negedge clock) begin
        exp_t e;
        bit   exp_rdy;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            chk("halted", 32'(halted), 32'(tb_halted));
            chk("halted_w2", 32'(halted2), 32'(tb_halted));
            chk("words_out", 32'(words_out), 32'(tb_cnt[15:0]));
            chk("words_out_w2", 32'(words_out2), 32'(tb_cnt[1:0]));
            if (prev_stall) begin
                chk("hold_valid", 32'(bus0.out_valid), 32'd1);
                chk("hold_word", 32'(bus0.out_word), 32'(prev_word));
                chk("hold_last", 32'(bus0.out_last), 32'(prev_last));
            end
            if (!bus0.out_valid) exp_rdy = !tb_halted;
            else if (bus0.out_ready && q.size() > 0) exp_rdy = !tb_halted && q[0].last && !q[0].sys;
            else exp_rdy = 1'b0;
            chk("in_ready", 32'(bus0.in_ready), 32'(exp_rdy));
            if (bus0.out_valid && bus0.out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_word", 32'(bus0.out_word), 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("out_word", 32'(bus0.out_word), 32'(e.w));
                    chk("out_last", 32'(bus0.out_last), 32'(e.last));
                    if (e.sys) tb_halted = 1'b1;
                end
                seen_word = bus0.out_word;
                tb_cnt++;
            end
            prev_stall = bus0.out_valid && !bus0.out_ready;
            prev_word  = bus0.out_word;
            prev_last  = bus0.out_last;
            if (err) obs_err++;
            if (err2) obs_err2++;
        end
    end

    initial begin
        bus0.in_valid = 1'b0;
        set_fields(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst_out_valid", 32'(bus0.out_valid), 32'd0);
        chk("rst_out_word", 32'(bus0.out_word), 32'd0);
        chk("rst_out_last", 32'(bus0.out_last), 32'd0);
        chk("rst_words_out", 32'(words_out), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_in_ready", 32'(bus0.in_ready), 32'd1);

        // R_TYPE single word
        rdy_mode = 1;
        send(0, 3, 1, 2, 4, 0, 0, 0);
        drain();
        chk("r_word", 32'(seen_word), 32'h4688);
        chk("r_count", 32'(words_out), 32'd1);

        // I_TYPE with sink stalled for three cycles
        rdy_mode = 0;
        send(1, 5, 7, 0, 2, 0, 0, 16'hBEEF);
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        chk("i_stall_valid", 32'(bus0.out_valid), 32'd1);
        chk("i_stall_word", 32'(bus0.out_word), 32'h2A39);
        chk("i_stall_last", 32'(bus0.out_last), 32'd0);
        rdy_mode = 1;
        drain();
        chk("i_word1", 32'(seen_word), 32'hBEEF);

        // J_TYPE
        send(3, 6, 0, 0, 0, 9'h1A5, 1, 0);
        drain();
        chk("j_word", 32'(seen_word), 32'hDC53);

        // Back-to-back R, M, B
        send(0, 1, 2, 3, 9, 0, 0, 0);
        send(4, 4, 5, 6, 7, 0, 0, 16'h1234);
        send(2, 0, 3, 4, 13, 9'h0B6, 0, 0);
        drain();

        // Randomized traffic with random sink backpressure and idle gaps
        rdy_mode = 2;
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock);
                #1;
            end
            send_rand(1'b0);
        end
        rdy_mode = 1;
        drain();

        // Reset while M_TYPE word1 is pending
        rdy_mode = 0;
        send(4, 2, 3, 4, 5, 0, 0, 16'hA5A5);
        rdy_mode = 1;
        @(posedge clock);
        #1;
        rdy_mode = 0;
        chk("w1_pending", 32'(bus0.out_valid && bus0.out_last && q.size() == 1), 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("w1_rst_valid", 32'(bus0.out_valid), 32'd0);
        chk("w1_rst_count", 32'(words_out), 32'd0);
        chk("w1_rst_count_w2", 32'(words_out2), 32'd0);
        q.delete();
        tb_cnt = 0;
        reset = 1'b0;
        rdy_mode = 1;
        repeat (3) begin
            @(posedge clock);
            #1;
        end

        // Five words on the CNT_W=2 copy wrap to 1
        for (int n = 0; n < 5; n++) send(0, n, n, n, n, 0, 0, 0);
        drain();
        chk("wrap_w2", 32'(words_out2), 32'd1);

        // SYS_END, then a bundle held valid that must never be taken
        send(5, 7, 7, 7, 15, 511, 1, 16'hFFFF);
        set_fields(0, 1, 1, 1, 1, 0, 0, 0);
        bus0.in_valid = 1'b1;
        repeat (10) begin
            @(posedge clock);
            #1;
        end
        bus0.in_valid = 1'b0;
        chk("sys_word", 32'(seen_word), 32'd5);
        chk("sys_halted", 32'(halted), 32'd1);
        chk("sys_in_ready", 32'(bus0.in_ready), 32'd0);
        chk("sys_no_more", 32'(q.size() == 0 && !bus0.out_valid), 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        q.delete();
        tb_cnt = 0;
        tb_halted = 1'b0;
        reset = 1'b0;
        chk("unhalt", 32'(halted), 32'd0);
        chk("unhalt_in_ready", 32'(bus0.in_ready), 32'd1);

        chk("err_pulses", 32'(obs_err), 32'(exp_err));
        chk("err_pulses_w2", 32'(obs_err2), 32'(exp_err));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
